alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- NREG, 16, number of general registers (register field width REGW = clog2(NREG)).
- OPC_W, 5, opcode width.
- MEM_TO, 15, max cycles waiting for mem_ready before error.
- OP_ADD, 5'b00011; OP_SUB, 5'b00100; OP_AND, 5'b00101; OP_OR, 5'b00110: register-register ops.
- OP_ADDI, 5'b01100; OP_ANDI, 5'b01101; OP_ORI, 5'b01110: immediate ops.
- OP_MUL, 5'b01111; OP_DIV, 5'b10000: HI/LO ops.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, named as in the codebase. Ports, one per line: name, direction, width, meaning (clock and reset first).
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- run  in  1  start and continue fetch/execute.
- ir  in  32  instruction register contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc, [18:0] C.
- mem_ready  in  1  memory read data valid.
- Rin, Rout  out  NREG  one-hot register load and drive enables.
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout  out  1 each  datapath controls.
- alu_op  out  OPC_W  ALU operation; 0 when no ALU op is active.
- busy  out  1  high in every state except IDLE and ERR.
- error  out  1  sticky fault flag.

Function
REQ-003 All outputs SHALL be decoded from the registered state (Moore), so each control is high for exactly the full cycle of its state.
REQ-004 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6 and ERR.
REQ-005 IDLE -> T0 when run=1; otherwise remain in IDLE with all controls 0.
REQ-006 T0 SHALL assert PCout, MARin, IncPC, Zin; next state T1.
REQ-007 T1 SHALL assert Zlowout, PCin, Read, MDRin.
- PCin and Zlowout only on the first T1 cycle.
- Read and MDRin held until the cycle mem_ready=1; exit to T2 after that cycle.
REQ-008 A wait counter SHALL count T1 cycles. If mem_ready has not been seen after MEM_TO cycles, go to ERR.
REQ-009 T2 SHALL assert MDRout and IRin; next state T3.
REQ-010 In T3, opcode SHALL be decoded from ir[31:27]. A value matching no parameter SHALL go to ERR; otherwise assert Rout[Rb] and Yin.
REQ-011 T4 SHALL assert Zin with alu_op=opcode.
- Register-register, MUL, DIV: Rout[Rc].
- Immediate: Cout.
REQ-012 T5, non-MUL/DIV, SHALL assert Zlowout and Rin[Ra]. If Ra=0, Rin stays all-zero (R0 write suppressed).
REQ-013 T5, MUL/DIV, SHALL assert Zlowout and LOin; T6 SHALL assert Zhighout and HIin.
REQ-014 After the final state (T5, or T6 for MUL/DIV): if run=1, go to T0 (back-to-back instructions); otherwise go to IDLE.
REQ-015 Latency from run sampled high to register write, with mem_ready=1 in first T1: 6 cycles; MUL/DIV LO+HI complete in 7; each mem_ready wait adds 1.
REQ-016 Rin and Rout SHALL each be all-zero or one-hot; never more than one bus driver at once.
REQ-017 ERR SHALL set error, drive all controls 0, and hold until reset. run SHALL be ignored in ERR.
REQ-018 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes and the block returns to IDLE.

Reset
REQ-019 clear=0 SHALL immediately force IDLE, clear the wait counter and error, and drive all outputs to 0, including mid-instruction.
REQ-020 The first state transition SHALL occur on the first rising clock edge after clear returns high.

Verification
REQ-021 clear low, run=1, ir=0x1A1B8000 (add R4,R3,R7), mem_ready=1 -> T0..T5. Required: Rout=0x0008 in T3; Rout=0x0080 and alu_op=00011 in T4; Rin=0x0010 in T5; busy then 0 if run=0.
REQ-022 ir=0x7A180000 (mul R4,R3,R0) -> T4 alu_op=01111; T5 Zlowout+LOin; T6 Zhighout+HIin; Rin stays 0 throughout.
REQ-023 addi with Ra=0 -> Cout high in T4; Rin=0 in T5.
REQ-024 mem_ready held low 3 cycles -> T1 lasts 4 cycles with Read=1, PCin pulsed once. mem_ready held low 16 cycles -> ERR, error=1 persists until clear.
REQ-025 Illegal opcode 5'b11111 -> ERR after T3 decode; clear pulse mid-T4 of a valid op -> all outputs 0 asynchronously, IDLE.
REQ-026 run held high across two adds -> T5 immediately followed by T0, no idle cycle; Rout one-hot checked every cycle.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: control bus between the ALU sequencer and its datapath/memory environment.
// Signals:
//   run        environment -> sequencer  start and continue fetch/execute
//   ir         environment -> sequencer  instruction register contents
//   mem_ready  environment -> sequencer  memory read data valid
//   Rin, Rout  sequencer -> datapath     one-hot register load / drive enables
//   PCout .. Cout                        single-bit datapath strobes
//   alu_op     sequencer -> datapath     ALU operation, 0 when idle
//   busy, error                          sequencer status
interface alu_sequencer_if #(
    parameter int NREG  = 16,
    parameter int OPC_W = 5
);
    logic             run;
    logic [31:0]      ir;
    logic             mem_ready;
    logic [NREG-1:0]  Rin;
    logic [NREG-1:0]  Rout;
    logic             PCout;
    logic             PCin;
    logic             IncPC;
    logic             MARin;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Zin;
    logic             Zlowout;
    logic             Zhighout;
    logic             HIin;
    logic             LOin;
    logic             Cout;
    logic [OPC_W-1:0] alu_op;
    logic             busy;
    logic             error;

    modport master (
        output run, ir, mem_ready,
        input  Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, alu_op, busy, error
    );

    modport slave (
        input  run, ir, mem_ready,
        output Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, alu_op, busy, error
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: Moore control sequencer for a single-bus ALU datapath (fetch, decode, execute).
// Ports:
//   clock  rising-edge clock
//   clear  asynchronous active-low reset
//   bus    alu_sequencer_if.slave: run/ir/mem_ready in; register enables, datapath strobes,
//          alu_op, busy and error out
module alu_sequencer #(
    parameter int               NREG    = 16,
    parameter int               OPC_W   = 5,
    parameter int               MEM_TO  = 15,
    parameter logic [OPC_W-1:0] OP_ADD  = 5'b00011,
    parameter logic [OPC_W-1:0] OP_SUB  = 5'b00100,
    parameter logic [OPC_W-1:0] OP_AND  = 5'b00101,
    parameter logic [OPC_W-1:0] OP_OR   = 5'b00110,
    parameter logic [OPC_W-1:0] OP_ADDI = 5'b01100,
    parameter logic [OPC_W-1:0] OP_ANDI = 5'b01101,
    parameter logic [OPC_W-1:0] OP_ORI  = 5'b01110,
    parameter logic [OPC_W-1:0] OP_MUL  = 5'b01111,
    parameter logic [OPC_W-1:0] OP_DIV  = 5'b10000
) (
    input logic            clock,
    input logic            clear,
    alu_sequencer_if.slave bus
);
    localparam int REGW = $clog2(NREG);
    localparam int WW   = $clog2(MEM_TO + 1);

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, ERR} state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait;
    logic             r_error;
    logic [OPC_W-1:0] r_op;
    logic [REGW-1:0]  r_ra;
    logic [REGW-1:0]  r_rc;

    function automatic logic is_rr(input logic [OPC_W-1:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR;
    endfunction

    function automatic logic is_imm(input logic [OPC_W-1:0] op);
        return op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
    endfunction

    function automatic logic is_md(input logic [OPC_W-1:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [REGW-1:0] r);
        return {{(NREG-1){1'b0}}, 1'b1} << r;
    endfunction

    logic [OPC_W-1:0] w_op;
    logic [REGW-1:0]  w_ra;
    logic [REGW-1:0]  w_rb;
    logic [REGW-1:0]  w_rc;
    logic             w_legal;
    logic             w_md;
    logic             w_imm;
    logic             w_first;
    logic             w_unused_ir;

    assign w_op        = bus.ir[31 -: OPC_W];
    assign w_ra        = bus.ir[26 -: REGW];
    assign w_rb        = bus.ir[22 -: REGW];
    assign w_rc        = bus.ir[18 -: REGW];
    assign w_unused_ir = ^bus.ir[14:0];
    assign w_legal     = is_rr(w_op) || is_imm(w_op) || is_md(w_op);
    // Execute-phase decisions use the opcode captured at decode, so a reload of ir cannot disturb them.
    assign w_md        = is_md(r_op);
    assign w_imm       = is_imm(r_op);
    // The wait counter is zero only on the first T1 cycle; PC update happens exactly once there.
    assign w_first     = r_wait == '0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_error <= 1'b0;
            r_op    <= '0;
            r_ra    <= '0;
            r_rc    <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= bus.run ? T0 : IDLE;
                T0: begin
                    r_state <= T1;
                    r_wait  <= '0;
                end
                T1: begin
                    r_wait <= r_wait + 1'b1;
                    if (bus.mem_ready) begin
                        r_state <= T2;
                    end else if (r_wait == WW'(MEM_TO - 1)) begin
                        r_state <= ERR;
                        r_error <= 1'b1;
                    end
                end
                T2: r_state <= T3;
                T3: begin
                    r_op <= w_op;
                    r_ra <= w_ra;
                    r_rc <= w_rc;
                    r_state <= w_legal ? T4 : ERR;
                    r_error <= !w_legal;
                end
                T4: r_state <= T5;
                T5: r_state <= w_md ? T6 : (bus.run ? T0 : IDLE);
                T6: r_state <= bus.run ? T0 : IDLE;
                // ERR holds until reset; any unreachable encoding is treated as a fault too.
                default: begin
                    r_state <= ERR;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign bus.PCout    = r_state == T0;
    assign bus.MARin    = r_state == T0;
    assign bus.IncPC    = r_state == T0;
    assign bus.Zin      = r_state == T0 || r_state == T4;
    assign bus.PCin     = r_state == T1 && w_first;
    assign bus.Zlowout  = (r_state == T1 && w_first) || r_state == T5;
    assign bus.Read     = r_state == T1;
    assign bus.MDRin    = r_state == T1;
    assign bus.MDRout   = r_state == T2;
    assign bus.IRin     = r_state == T2;
    assign bus.Yin      = r_state == T3 && w_legal;
    assign bus.Cout     = r_state == T4 && w_imm;
    assign bus.LOin     = r_state == T5 && w_md;
    assign bus.Zhighout = r_state == T6;
    assign bus.HIin     = r_state == T6;
    assign bus.alu_op   = r_state == T4 ? r_op : '0;
    // Only one register ever drives the bus: Rb at decode, Rc as the second operand.
    assign bus.Rout     = (r_state == T3 && w_legal) ? onehot(w_rb) :
                          (r_state == T4 && !w_imm)  ? onehot(r_rc) : '0;
    // R0 is hardwired, so a write to it is suppressed.
    assign bus.Rin      = (r_state == T5 && !w_md && r_ra != '0) ? onehot(r_ra) : '0;
    assign bus.busy     = r_state != IDLE && r_state != ERR;
    assign bus.error    = r_error;

    a_single_driver: assert property (@(posedge clock) disable iff (!clear)
        $onehot0(bus.Rin) && $onehot0(bus.Rout));
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed check of alu_sequencer against a per-cycle behavioural model.
module tb_alu_sequencer;
    localparam int MEM_TO = 15;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        pcout, pcin, incpc, marin, read, mdrin, mdrout, irin;
        logic        yin, zin, zlowout, zhighout, hiin, loin, cout;
        logic [4:0]  alu_op;
        logic        busy, error;
    } ctl_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    alu_sequencer_if bus ();
    alu_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

    ctl_t       exp_q[$];
    ctl_t       trace[$];
    ctl_t       act_v;
    int         n_checks = 0;
    int         n_fail = 0;
    int         b;
    int         pc_cnt;
    bit         cont;
    logic [4:0] ops[9] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                           5'b01101, 5'b01110, 5'b01111, 5'b10000};

    function automatic ctl_t dut_ctl();
        return {bus.Rin, bus.Rout, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read,
                bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
                bus.HIin, bus.LOin, bus.Cout, bus.alu_op, bus.busy, bus.error};
    endfunction

    function automatic ctl_t busy_v();
        ctl_t c = '0;
        c.busy = 1'b1;
        return c;
    endfunction

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Instruction class from the opcode table: 0 illegal, 1 reg-reg, 2 immediate, 3 HI/LO.
    function automatic int kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 1;
            5'b01100, 5'b01101, 5'b01110:           return 2;
            5'b01111, 5'b10000:                     return 3;
            default:                                return 0;
        endcase
    endfunction

    task automatic chk(input string name, input ctl_t act, input ctl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            act_v = dut_ctl();
            trace.push_back(act_v);
            chk("cycle", act_v, exp_q.pop_front());
            n_checks++;
            if (!$onehot0(act_v.rin) || !$onehot0(act_v.rout)) begin
                n_fail++;
                $display("FAIL onehot @%0t: got Rin=%h Rout=%h expected at most one bit each", $time, act_v.rin, act_v.rout);
            end
        end
    end

    // One clock cycle: drive inputs for the current cycle, queue what the outputs must be in it.
    task automatic step(input ctl_t e, input logic run_v, input logic mr);
        bus.run = run_v;
        bus.mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic err_cycles(input int n);
        ctl_t e = '0;
        e.error = 1'b1;
        repeat (n) step(e, rnd(), rnd());
    endtask

    // Called at the start of T0; lows = cycles mem_ready stays low in T1.
    task automatic do_instr(input logic [31:0] irv, input int lows, input bit run_next, input bit clr_t4);
        ctl_t e;
        logic [4:0] op = irv[31:27];
        logic [3:0] ra = irv[26:23];
        logic [3:0] rb = irv[22:19];
        logic [3:0] rc = irv[18:15];
        int k = kind(op);
        e = busy_v(); e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
        step(e, rnd(), rnd());
        for (int i = 0; i <= lows && i < MEM_TO; i++) begin
            e = busy_v(); e.read = 1; e.mdrin = 1; e.pcin = (i == 0); e.zlowout = (i == 0);
            step(e, rnd(), i == lows);
        end
        if (lows >= MEM_TO) begin
            err_cycles(3);
            return;
        end
        bus.ir = irv;
        e = busy_v(); e.mdrout = 1; e.irin = 1;
        step(e, rnd(), rnd());
        e = busy_v();
        if (k != 0) begin
            e.rout = 16'(1) << rb;
            e.yin = 1;
        end
        step(e, rnd(), rnd());
        if (k == 0) begin
            err_cycles(3);
            return;
        end
        e = busy_v(); e.zin = 1; e.alu_op = op;
        if (k == 2) e.cout = 1;
        else e.rout = 16'(1) << rc;
        if (clr_t4) begin
            chk("t4_before_clear", dut_ctl(), e);
            clear = 1'b0;
            #1;
            chk("clear_async", dut_ctl(), '0);
            step('0, 1'b0, 1'b0);
            clear = 1'b1;
            return;
        end
        step(e, rnd(), rnd());
        e = busy_v(); e.zlowout = 1;
        if (k == 3) e.loin = 1;
        else e.rin = (ra == 0) ? 16'h0 : 16'(1) << ra;
        if (k != 3) begin
            step(e, run_next, rnd());
            return;
        end
        step(e, rnd(), rnd());
        e = busy_v(); e.zhighout = 1; e.hiin = 1;
        step(e, run_next, rnd());
    endtask

    task automatic do_reset();
        clear = 1'b0;
        step('0, rnd(), rnd());
        clear = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run = 1'b1;
        bus.ir = 32'h0;
        bus.mem_ready = 1'b1;
        #1 clear = 1'b0;
        #1 chk("reset_async", dut_ctl(), '0);
        @(posedge clock);
        #1;
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        clear = 1'b1;
        step('0, 1'b1, 1'b1);

        b = trace.size();
        do_instr(32'h1A1B8000, 0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        pin("add_t3_rout", 32'(trace[b+3].rout), 32'h0008);
        pin("add_t4_rout", 32'(trace[b+4].rout), 32'h0080);
        pin("add_t4_aluop", 32'(trace[b+4].alu_op), 32'h03);
        pin("add_t5_rin", 32'(trace[b+5].rin), 32'h0010);
        pin("add_idle_busy", 32'(trace[b+6].busy), 32'h0);

        step('0, 1'b1, 1'b0);
        b = trace.size();
        do_instr(32'h7A180000, 0, 1'b0, 1'b0);
        pin("mul_t4_aluop", 32'(trace[b+4].alu_op), 32'h0F);
        pin("mul_t4_rout", 32'(trace[b+4].rout), 32'h0001);
        pin("mul_t5_lo", 32'({trace[b+5].zlowout, trace[b+5].loin}), 32'h3);
        pin("mul_t6_hi", 32'({trace[b+6].zhighout, trace[b+6].hiin}), 32'h3);
        for (int i = 0; i < 7; i++) pin("mul_rin_zero", 32'(trace[b+i].rin), 32'h0);

        step('0, 1'b1, 1'b0);
        b = trace.size();
        do_instr({5'b01100, 4'd0, 4'd5, 4'd2, 15'h1234}, 0, 1'b0, 1'b0);
        pin("addi_t4_cout", 32'(trace[b+4].cout), 32'h1);
        pin("addi_r0_rin", 32'(trace[b+5].rin), 32'h0);

        step('0, 1'b1, 1'b0);
        b = trace.size();
        do_instr(32'h1A1B8000, 3, 1'b0, 1'b0);
        pc_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            pin("wait_read", 32'(trace[b+i].read), 32'h1);
            pc_cnt += int'(trace[b+i].pcin);
        end
        pin("wait_pcin_once", 32'(pc_cnt), 32'h1);
        pin("wait_then_t2", 32'(trace[b+5].irin), 32'h1);

        step('0, 1'b1, 1'b0);
        b = trace.size();
        do_instr(32'h1A1B8000, 0, 1'b1, 1'b0);
        do_instr({5'b00100, 4'd9, 4'd1, 4'd2, 15'h0}, 1, 1'b0, 1'b0);
        pin("b2b_t0_after_t5", 32'({trace[b+6].pcout, trace[b+6].busy}), 32'h3);

        step('0, 1'b1, 1'b0);
        b = trace.size();
        do_instr(32'h1A1B8000, 16, 1'b0, 1'b0);
        pin("timeout_t1_15", 32'(trace[b+15].read), 32'h1);
        pin("timeout_err", 32'({trace[b+16].error, trace[b+16].busy}), 32'h2);
        pin("err_sticky", 32'(trace[trace.size()-1].error), 32'h1);
        do_reset();
        pin("err_cleared", 32'(bus.error), 32'h0);

        step('0, 1'b1, 1'b0);
        b = trace.size();
        do_instr(32'hF8000000, 0, 1'b0, 1'b0);
        pin("illegal_no_yin", 32'({trace[b+3].yin, trace[b+3].rout}), 32'h0);
        pin("illegal_err", 32'(trace[b+4].error), 32'h1);
        do_reset();

        step('0, 1'b1, 1'b0);
        do_instr(32'h1A1B8000, 0, 1'b0, 1'b1);
        pin("clear_idle_busy", 32'(bus.busy), 32'h0);

        cont = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!cont) begin
                repeat ($urandom_range(0, 2)) step('0, 1'b0, rnd());
                step('0, 1'b1, rnd());
            end
            cont = (n < 39) ? rnd() : 1'b0;
            do_instr({ops[$urandom_range(0, 8)], 27'($urandom)}, $urandom_range(0, 4), cont, 1'b0);
        end
        step('0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
